// File: rtl/div3_pkg.sv
// Shared types and helpers for the serial divisibility-by-3 collector family.
package div3_pkg;

    // Default word width for collectors built on this package.
    localparam int WORD_W_DEFAULT = 32;

    // Running remainder of the bits seen so far, modulo 3.
    typedef enum logic [1:0] {
        REM0 = 2'd0,
        REM1 = 2'd1,
        REM2 = 2'd2
    } rem_t;

    // Occupancy of the single-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Shifting one more bit in, MSB first, maps remainder r to (2r + b) mod 3.
    function automatic rem_t rem_next(input rem_t r, input logic b);
        rem_t res;
        case (r)
            REM0:    res = b ? REM1 : REM0;
            REM1:    res = b ? REM0 : REM2;
            REM2:    res = b ? REM2 : REM1;
            default: res = REM0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/div3_rem_fsm.sv
// Running mod-3 remainder register for an MSB-first bit stream.
// clr wins over en so a word boundary can restart the remainder at REM0.
module div3_rem_fsm
    import div3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] rem
);

    rem_t rem_q;
    rem_t rem_d;

    // Next remainder: clear, advance by one bit, or hold.
    always_comb begin
        // NOTE: the default is assigned before any branch so every path drives rem_d and no latch is inferred.
        rem_d = rem_q;
        if (clr) begin
            rem_d = REM0;
        end else if (en) begin
            rem_d = rem_next(rem_q, bit_in);
        end
    end

    // Remainder register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: flops are written with <= so each one samples pre-edge values independent of statement order.
        if (rst) begin
            rem_q <= REM0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/div3_serial_collector.sv
// Bit-serial (MSB first) word collector with a sequential mod-3 reference.
// Completed words land in a one-entry output slot behind a valid/ready port;
// collection of the next word continues while the slot is occupied.
module div3_serial_collector
    import div3_pkg::*;
#(
    parameter int WORD_W = div3_pkg::WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic [WORD_W-1:0] word_out,
    output logic [1:0]        rem_out,
    output logic              div3_out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WORD_W - 1);

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    rem_t              rem_out_q, rem_out_d;
    logic              div3_q, div3_d;
    slot_state_t       state_q, state_d;

    logic [1:0] rem_cur;
    rem_t       rem_step;
    logic       last_bit;
    logic       slot_full;
    logic       accept;
    logic       complete;
    logic       pop;

    // Handshake decode: only the final bit of a word stalls, and only while the slot is held.
    always_comb begin
        last_bit  = (bit_cnt_q == LAST_CNT);
        slot_full = (state_q == SLOT_FULL);
        bit_ready = !(last_bit && slot_full && !out_ready);
        accept    = bit_valid && bit_ready;
        complete  = accept && last_bit;
        pop       = slot_full && out_ready;
        rem_step  = rem_next(rem_t'(rem_cur), bit_in);
    end

    div3_rem_fsm u_rem_fsm (
        .clk    (clk),
        .rst    (rst),
        .clr    (complete),
        .en     (accept),
        .bit_in (bit_in),
        .rem    (rem_cur)
    );

    // Collection datapath: bit counter and shift register, both restarted at word completion.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        if (complete) begin
            bit_cnt_d = '0;
            shreg_d   = '0;
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = {shreg_q[WORD_W-2:0], bit_in};
        end
    end

    // Output slot contents: load on completion, otherwise hold (stable under back-pressure).
    always_comb begin
        word_d    = word_q;
        rem_out_d = rem_out_q;
        div3_d    = div3_q;
        if (complete) begin
            word_d    = {shreg_q[WORD_W-2:0], bit_in};
            rem_out_d = rem_step;
            div3_d    = (rem_step == REM0);
        end
    end

    // Slot occupancy: a pop coinciding with a completion keeps the slot full (no bubble).
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (complete)         state_d = SLOT_FULL;
            SLOT_FULL:  if (pop && !complete) state_d = SLOT_EMPTY;
            default:                          state_d = SLOT_EMPTY;
        endcase
    end

    // All collector and slot registers; reset discards any partial word and pending output.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            word_q    <= '0;
            rem_out_q <= REM0;
            div3_q    <= 1'b0;
            state_q   <= SLOT_EMPTY;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            rem_out_q <= rem_out_d;
            div3_q    <= div3_d;
            state_q   <= state_d;
        end
    end

    assign word_out  = word_q;
    assign rem_out   = rem_out_q;
    assign div3_out  = div3_q;
    assign out_valid = slot_full;

endmodule

// File: tb/tb_div3_serial_collector.sv
// Self-checking bench for div3_serial_collector: directed scenarios plus
// randomized words, gaps and back-pressure against an arithmetic reference.
module tb_div3_serial_collector;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [W-1:0] word_out;
    logic [1:0]   rem_out;
    logic         div3_out;
    logic         out_valid;
    logic         out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    bit           watch_valid = 1'b0;
    bit           rand_ready  = 1'b0;

    div3_serial_collector #(.WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .word_out  (word_out),
        .rem_out   (rem_out),
        .div3_out  (div3_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the remainder is simply the word's value modulo 3.
    function automatic logic [1:0] ref_rem(input logic [W-1:0] w);
        return 2'(w % 32'd3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(input logic [W-1:0] w);
        check("slot_valid", 32'(out_valid), 32'd1);
        check("slot_word",  word_out, w);
        check("slot_rem",   32'(rem_out), 32'(ref_rem(w)));
        check("slot_div3",  32'(div3_out), 32'(ref_rem(w) == 2'd0));
    endtask

    // Present one bit and wait (bounded) until it is accepted.
    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bit_ready) begin
                step();
                return;
            end
        end
        check("bit_accept_timeout", 32'(bit_ready), 32'd1);
    endtask

    // Stream a whole word MSB first with optional random idle gaps, then expect it.
    task automatic send_word(input logic [W-1:0] w, input int gap_pct);
        for (int i = W - 1; i >= 0; i--) begin
            for (int g = 0; g < 6 && $urandom_range(99) < gap_pct; g++) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom_range(1));
                step();
            end
            send_bit(w[i]);
        end
        bit_valid = 1'b0;
        exp_q.push_back(w);
    endtask

    // Output monitor: every transfer must match the oldest expected word.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                check("pop_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pop_word", word_out, e);
                    check("pop_rem",  32'(rem_out), 32'(ref_rem(e)));
                    check("pop_div3", 32'(div3_out), 32'(ref_rem(e) == 2'd0));
                end
            end
            if (watch_valid) begin
                check("no_bubble", 32'(out_valid), 32'd1);
            end
        end
    end

    // Random back-pressure generator, active only when enabled.
    initial begin
        forever begin
            step();
            if (rand_ready) begin
                out_ready = 1'($urandom_range(1));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] t2_words[3];
        t2_words[0] = 32'hFFFF_FFFF;
        t2_words[1] = 32'h8000_0000;
        t2_words[2] = 32'd7;

        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_word_out",  word_out, 32'd0);
        check("rst_rem_out",   32'(rem_out), 32'd0);
        check("rst_div3_out",  32'(div3_out), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_bit_ready", 32'(bit_ready), 32'd1);
        step();

        // Single word with latency check: slot valid one edge after the last accept
        out_ready = 1'b1;
        send_word(32'd3, 0);
        @(negedge clk);
        check_slot(32'd3);
        step();

        // Remainder corner patterns
        foreach (t2_words[k]) begin
            send_word(t2_words[k], 0);
            @(negedge clk);
            check_slot(t2_words[k]);
            step();
        end

        // Back-pressure: final bit of the second word stalls while the slot holds 7
        out_ready = 1'b0;
        send_word(32'd7, 0);
        @(negedge clk);
        check_slot(32'd7);
        step();
        w = 32'd9;
        for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
        bit_valid = 1'b1;
        bit_in    = w[0];
        repeat (4) begin
            @(negedge clk);
            check("stall_bit_ready", 32'(bit_ready), 32'd0);
            check("hold_valid",      32'(out_valid), 32'd1);
            check("hold_word",       word_out, 32'd7);
            check("hold_rem",        32'(rem_out), 32'd1);
        end
        step();
        out_ready = 1'b1;
        send_bit(w[0]);
        bit_valid = 1'b0;
        exp_q.push_back(w);
        @(negedge clk);
        check_slot(32'd9);
        step();

        // Back-to-back: pop and completion on the same edge leave no bubble
        out_ready = 1'b0;
        send_word(32'd5, 0);
        @(negedge clk);
        check_slot(32'd5);
        watch_valid = 1'b1;
        step();
        w = 32'd6;
        for (int i = W - 1; i >= 1; i--) send_bit(w[i]);
        out_ready = 1'b1;
        send_bit(w[0]);
        bit_valid = 1'b0;
        exp_q.push_back(w);
        @(negedge clk);
        check_slot(32'd6);
        watch_valid = 1'b0;
        step();

        // Random input gaps
        send_word(32'h1234_5678, 50);
        @(negedge clk);
        check_slot(32'h1234_5678);
        step();

        // Reset mid-word: partial bits are dropped
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(1)));
        bit_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midword_rst_valid", 32'(out_valid), 32'd0);
        check("midword_rst_word",  word_out, 32'd0);
        step();
        send_word(32'd4, 0);
        @(negedge clk);
        check_slot(32'd4);
        step();

        // Reset while the slot is held
        out_ready = 1'b0;
        w = $urandom | 32'h1;
        send_word(w, 30);
        @(negedge clk);
        check_slot(w);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("hold_rst_valid", 32'(out_valid), 32'd0);
        check("hold_rst_word",  word_out, 32'd0);
        check("hold_rst_rem",   32'(rem_out), 32'd0);
        check("hold_rst_div3",  32'(div3_out), 32'd0);
        step();

        // Randomized words, gaps and back-pressure
        rand_ready = 1'b1;
        repeat (20) send_word($urandom, 25);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (5) step();
        check("drain_all_consumed", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
